pacman_motion_ctrl: RTL

- Per-frame sequencer for the pacman sprite renderer.
- Owns pacman centre position (xloc/yloc), facing direction, alive flag and animation frame index, and feeds them to the sprite graphics block.
- Buffers joystick direction requests, takes turns only at tile centres, stops against walls, wraps through the side tunnel, and runs the death/respawn/lives sequence.

---
 rtl/pacman_motion_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pacman_motion_ctrl.sv
// rtl/pacman_motion_ctrl.sv - pacman position, direction, animation and life sequencer
module pacman_motion_ctrl #(
  parameter logic [9:0] START_X      = 10'd327,
  parameter logic [9:0] START_Y      = 10'd247,
  parameter logic [1:0] START_DIR    = 2'b11,
  parameter logic [9:0] X_MIN        = 10'd7,
  parameter logic [9:0] X_MAX        = 10'd631,
  parameter int         MOVE_DIV     = 2,
  parameter int         ANIM_DIV     = 4,
  parameter int         DEATH_FRAMES = 60,
  parameter logic [1:0] LIVES        = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       dir_req_valid,
  input  logic [1:0] dir_req,
  input  logic [3:0] wall,
  input  logic       ghost_hit,
  output logic [9:0] xloc,
  output logic [9:0] yloc,
  output logic [1:0] pacman_dir,
  output logic       pacman_alive,
  output logic [1:0] animation_cycle,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       moving
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_DYING = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [1:0] D_RT = 2'b00;
  localparam logic [1:0] D_UP = 2'b01;
  localparam logic [1:0] D_DN = 2'b10;

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_DIV - 1);
  localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

  logic [1:0]    state;
  logic [1:0]    pend_dir;
  logic          anim_down;
  logic [MW-1:0] move_cnt;
  logic [AW-1:0] anim_cnt;
  logic [DW-1:0] death_cnt;

  logic          aligned;
  logic [1:0]    step_dir;
  logic          blocked;
  logic [9:0]    next_x;
  logic [9:0]    next_y;
  logic [1:0]    next_cycle;
  logic          next_down;
  logic          respawn;

  // Direction choice, wall test, next position and next animation frame for a step
  always_comb begin
    aligned  = (xloc[3:0] == 4'd7) && (yloc[3:0] == 4'd7);
    step_dir = pacman_dir;
    if (pend_dir == (pacman_dir ^ 2'b11)) begin
      step_dir = pend_dir;
    end else if (aligned && !wall[pend_dir]) begin
      step_dir = pend_dir;
    end
    blocked = aligned && wall[step_dir];

    next_x = xloc;
    next_y = yloc;
    case (step_dir)
      D_RT:    next_x = (xloc == X_MAX) ? X_MIN : xloc + 10'd1;
      D_UP:    next_y = yloc - 10'd1;
      D_DN:    next_y = yloc + 10'd1;
      default: next_x = (xloc == X_MIN) ? X_MAX : xloc - 10'd1;
    endcase

    // Ping-pong 0,1,2,1,0,...; anim_down flips at the ends
    next_cycle = animation_cycle;
    next_down  = anim_down;
    if (!anim_down) begin
      if (animation_cycle == 2'd2) begin
        next_cycle = 2'd1;
        next_down  = 1'b1;
      end else begin
        next_cycle = animation_cycle + 2'd1;
      end
    end else begin
      if (animation_cycle == 2'd0) begin
        next_cycle = 2'd1;
        next_down  = 1'b0;
      end else begin
        next_cycle = animation_cycle - 2'd1;
      end
    end

    respawn = ((state == S_DYING) && frame_tick && (death_cnt == DEATH_LAST) && (lives > 2'd1))
           || ((state == S_OVER) && start);
  end

  // Game state sequencer and all sprite registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      xloc            <= START_X;
      yloc            <= START_Y;
      pacman_dir      <= START_DIR;
      pend_dir        <= START_DIR;
      pacman_alive    <= 1'b1;
      animation_cycle <= 2'd0;
      anim_down       <= 1'b0;
      lives           <= LIVES;
      game_over       <= 1'b0;
      moving          <= 1'b0;
      move_cnt        <= '0;
      anim_cnt        <= '0;
      death_cnt       <= '0;
    end else begin
      if (dir_req_valid) begin
        pend_dir <= dir_req;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (ghost_hit) begin
            state           <= S_DYING;
            pacman_alive    <= 1'b0;
            moving          <= 1'b0;
            animation_cycle <= 2'd0;
            death_cnt       <= '0;
          end else if (frame_tick) begin
            if (move_cnt == MOVE_LAST) begin
              move_cnt   <= '0;
              pacman_dir <= step_dir;
              if (blocked) begin
                moving <= 1'b0;
              end else begin
                moving <= 1'b1;
                xloc   <= next_x;
                yloc   <= next_y;
                if (anim_cnt == ANIM_LAST) begin
                  anim_cnt        <= '0;
                  animation_cycle <= next_cycle;
                  anim_down       <= next_down;
                end else begin
                  anim_cnt <= anim_cnt + 1'b1;
                end
              end
            end else begin
              move_cnt <= move_cnt + 1'b1;
            end
          end
        end
        S_DYING: begin
          if (frame_tick) begin
            if (death_cnt == DEATH_LAST) begin
              if (lives > 2'd1) begin
                lives <= lives - 2'd1;
                state <= S_MOVE;
              end else begin
                lives     <= 2'd0;
                game_over <= 1'b1;
                state     <= S_OVER;
              end
            end else begin
              death_cnt <= death_cnt + 1'b1;
            end
          end
        end
        S_OVER: begin
          if (start) begin
            lives     <= LIVES;
            game_over <= 1'b0;
            state     <= S_MOVE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Respawn overrides any same-cycle pend_dir load
      if (respawn) begin
        xloc            <= START_X;
        yloc            <= START_Y;
        pacman_dir      <= START_DIR;
        pend_dir        <= START_DIR;
        pacman_alive    <= 1'b1;
        animation_cycle <= 2'd0;
        anim_down       <= 1'b0;
        moving          <= 1'b0;
        move_cnt        <= '0;
        anim_cnt        <= '0;
        death_cnt       <= '0;
      end
    end
  end

endmodule
